// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit single-port memory between fetch and data; 32-bit data runs as two beats; optional starvation guard under ARB_FAIR_EN.
// Memory ports are combinational; read responses arrive 1 cycle after issue (2 for wide); fetch is stalled while data owns the port.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [15:0]       o_if_rdata,
  output logic              o_stall_fetch,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic              i_dm_wide,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_valid,
  output logic [31:0]       o_dm_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata
);

  typedef enum logic {S_IDLE, S_WIDE2} state_t;

  state_t      r_state;
  logic        r_if_pend;
  logic        r_dm_narrow;
  logic        r_dm_lo_pend;
  logic        r_dm_hi_pend;
  logic [15:0] r_lo;

  logic w_idle;
  logic w_wide2;
  logic w_force;
  logic w_if_issue;
  logic w_dm_beat0;

  // Reset gates every issue term so all outputs read 0 while rst is high.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_wide2    = (r_state == S_WIDE2) && !rst;
  assign w_if_issue = w_idle && i_if_req && (!i_dm_req || w_force);
  assign w_dm_beat0 = w_idle && i_dm_req && !w_if_issue;

`ifdef ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve;

  assign w_force = (r_starve >= CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_if_issue) begin
      r_starve <= '0;
    end else if (i_if_req && (r_starve < CNT_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign o_mem_en    = w_if_issue || w_dm_beat0 || w_wide2;
  assign o_mem_we    = (w_dm_beat0 || w_wide2) && i_dm_we;
  assign o_mem_addr  = w_wide2    ? i_dm_addr + ADDR_W'(1) :
                       w_dm_beat0 ? i_dm_addr :
                       w_if_issue ? i_if_addr : '0;
  assign o_mem_wdata = w_wide2    ? i_dm_wdata[31:16] :
                       w_dm_beat0 ? i_dm_wdata[15:0]  : 16'h0;

  assign o_if_gnt      = w_if_issue;
  assign o_stall_fetch = !rst && i_if_req && !w_if_issue;
  assign o_dm_gnt      = (w_dm_beat0 && !i_dm_wide) || w_wide2;

  // A flush in the response cycle kills the fetch issued one cycle earlier.
  assign o_if_valid = !rst && r_if_pend && !i_flush;
  assign o_if_rdata = o_if_valid ? i_mem_rdata : 16'h0;

  assign o_dm_valid = !rst && (r_dm_narrow || r_dm_hi_pend);
  assign o_dm_rdata = !o_dm_valid  ? 32'h0 :
                      r_dm_hi_pend ? {i_mem_rdata, r_lo} :
                                     {16'h0, i_mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_if_pend    <= 1'b0;
      r_dm_narrow  <= 1'b0;
      r_dm_lo_pend <= 1'b0;
      r_dm_hi_pend <= 1'b0;
      r_lo         <= 16'h0;
    end else begin
      r_state      <= (w_dm_beat0 && i_dm_wide) ? S_WIDE2 : S_IDLE;
      // Same-cycle flush kills the fetch issued alongside it.
      r_if_pend    <= w_if_issue && !i_flush;
      r_dm_narrow  <= w_dm_beat0 && !i_dm_wide && !i_dm_we;
      r_dm_lo_pend <= w_dm_beat0 && i_dm_wide && !i_dm_we;
      r_dm_hi_pend <= w_wide2 && !i_dm_we;
      if (r_dm_lo_pend) begin
        r_lo <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a behavioural synchronous memory; fairness checks run when ARB_FAIR_EN is defined.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              i_flush;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_valid;
  logic [15:0]       o_if_rdata;
  logic              o_stall_fetch;
  logic              i_dm_req;
  logic              i_dm_we;
  logic              i_dm_wide;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [31:0]       i_dm_wdata;
  logic              o_dm_gnt;
  logic              o_dm_valid;
  logic [31:0]       o_dm_rdata;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [15:0]       o_mem_wdata;
  logic [15:0]       i_mem_rdata;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata), .o_stall_fetch(o_stall_fetch),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_wide(i_dm_wide),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt),
    .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_en && o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_en && !o_mem_we) i_mem_rdata <= mem[o_mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Response monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (o_if_valid) begin
        if (exp_if.size() == 0) check_eq("if_unexpected_valid", 32'(o_if_rdata), 32'hFFFF_FFFF);
        else begin e = exp_if.pop_front(); check_eq("if_rdata", 32'(o_if_rdata), e); end
      end
      if (o_dm_valid) begin
        if (exp_dm.size() == 0) check_eq("dm_unexpected_valid", o_dm_rdata, 32'hFFFF_FFFF);
        else begin e = exp_dm.pop_front(); check_eq("dm_rdata", o_dm_rdata, e); end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_flush = 0; i_if_req = 0; i_dm_req = 0; i_dm_we = 0; i_dm_wide = 0;
  endtask

  task automatic dm_set(input logic we, input logic wide, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    i_dm_req = 1; i_dm_we = we; i_dm_wide = wide; i_dm_addr = a; i_dm_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0;
    mem[12'h010] = 16'h1111; mem[12'h011] = 16'h2222; mem[12'h012] = 16'h3333;
    mem[12'h013] = 16'h4444; mem[12'hFFF] = 16'hBEEF; mem[12'h000] = 16'hDEAD;
    i_mem_rdata = 16'h0; i_if_addr = '0; i_dm_addr = '0; i_dm_wdata = '0;
    quiet();

    // Reset with both requesters active: every output must be 0.
    rst = 1; i_if_req = 1; i_if_addr = 12'h010; dm_set(0, 0, 12'h020, 32'h0);
    @(negedge clk);
    check_eq("rst_mem_en", 32'(o_mem_en), 0);
    check_eq("rst_mem_addr", 32'(o_mem_addr), 0);
    check_eq("rst_gnts", {30'h0, o_if_gnt, o_dm_gnt}, 0);
    check_eq("rst_stall", 32'(o_stall_fetch), 0);
    check_eq("rst_valids", {30'h0, o_if_valid, o_dm_valid}, 0);
    next_cycle();
    rst = 0; quiet();
    next_cycle();

    // Fetch only, three consecutive addresses.
    for (int k = 0; k < 3; k++) begin
      i_if_req = 1; i_if_addr = ADDR_W'(12'h010 + k);
      @(negedge clk);
      check_eq("fetch_gnt", 32'(o_if_gnt), 1);
      check_eq("fetch_mem", {o_mem_en, o_mem_we, 18'h0, o_mem_addr}, {2'b10, 18'h0, ADDR_W'(12'h010 + k)});
      if (k > 0) check_eq("fetch_valid_timing", 32'(o_if_valid), 1);
      exp_if.push_back(32'h1111 * (k + 1));
      next_cycle();
    end
    quiet();
    @(negedge clk);
    check_eq("fetch_last_valid", 32'(o_if_valid), 1);
    next_cycle();

    // Wide read with wrap while fetch is waiting.
    i_if_req = 1; i_if_addr = 12'h013; dm_set(0, 1, 12'hFFF, 32'h0);
    @(negedge clk);
    check_eq("wide_b0_addr", 32'(o_mem_addr), 32'hFFF);
    check_eq("wide_b0_gnt", {30'h0, o_dm_gnt, o_if_gnt}, 0);
    check_eq("wide_b0_stall", 32'(o_stall_fetch), 1);
    exp_dm.push_back(32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check_eq("wide_b1_addr", 32'(o_mem_addr), 32'h000);
    check_eq("wide_b1_gnt", {30'h0, o_dm_gnt, o_if_gnt}, 32'b10);
    check_eq("wide_b1_stall", 32'(o_stall_fetch), 1);
    next_cycle();
    i_dm_req = 0;
    @(negedge clk);
    check_eq("wide_valid_timing", 32'(o_dm_valid), 1);
    check_eq("fetch_after_wide", {o_if_gnt, 19'h0, o_mem_addr}, {1'b1, 19'h0, 12'h013});
    exp_if.push_back(32'h4444);
    next_cycle();
    quiet();
    next_cycle();

    // Narrow write, then read it back.
    dm_set(1, 0, 12'h020, 32'h0000A5A5);
    @(negedge clk);
    check_eq("nw_mem", {o_mem_en, o_mem_we, o_dm_gnt, 1'b0, o_mem_addr, o_mem_wdata}, {4'b1110, 12'h020, 16'hA5A5});
    next_cycle();
    quiet();
    @(negedge clk);
    check_eq("nw_no_valid", 32'(o_dm_valid), 0);
    next_cycle();

    // Wide write, then wide read back.
    dm_set(1, 1, 12'h030, 32'h12345678);
    @(negedge clk);
    check_eq("ww_b0", {o_mem_we, o_dm_gnt, 2'b0, o_mem_addr, o_mem_wdata}, {4'b1000, 12'h030, 16'h5678});
    next_cycle();
    @(negedge clk);
    check_eq("ww_b1", {o_mem_we, o_dm_gnt, 2'b0, o_mem_addr, o_mem_wdata}, {4'b1100, 12'h031, 16'h1234});
    next_cycle();
    dm_set(0, 1, 12'h030, 32'h0);
    exp_dm.push_back(32'h12345678);
    next_cycle();
    next_cycle();
    quiet();
    next_cycle();

    // Flush kills fetches issued in the flush cycle and the one before.
    i_if_req = 1; i_if_addr = 12'h011;
    next_cycle();
    i_if_req = 0; i_flush = 1;
    @(negedge clk);
    check_eq("flush_kill_prev", 32'(o_if_valid), 0);
    next_cycle();
    i_if_req = 1; i_if_addr = 12'h012;
    @(negedge clk);
    check_eq("flush_gnt_continues", 32'(o_if_gnt), 1);
    next_cycle();
    i_flush = 0; i_if_addr = 12'h010;
    @(negedge clk);
    check_eq("flush_kill_same", 32'(o_if_valid), 0);
    exp_if.push_back(32'h1111);
    next_cycle();
    quiet();
    @(negedge clk);
    check_eq("post_flush_valid", 32'(o_if_valid), 1);
    next_cycle();

    // Flush does not touch DM reads.
    i_flush = 1; dm_set(0, 0, 12'h020, 32'h0);
    exp_dm.push_back(32'h0000A5A5);
    next_cycle();
    i_dm_req = 0;
    @(negedge clk);
    check_eq("flush_dm_valid", 32'(o_dm_valid), 1);
    next_cycle();
    quiet();
    next_cycle();

    // Reset during the second beat abandons the access.
    i_if_req = 1; i_if_addr = 12'h010; dm_set(0, 1, 12'h030, 32'h0);
    next_cycle();
    rst = 1;
    @(negedge clk);
    check_eq("rstw_mem_en", 32'(o_mem_en), 0);
    check_eq("rstw_dm_gnt", 32'(o_dm_gnt), 0);
    next_cycle();
    rst = 0; i_dm_req = 0;
    @(negedge clk);
    check_eq("rstw_if_gnt", 32'(o_if_gnt), 1);
    check_eq("rstw_no_dm_valid", 32'(o_dm_valid), 0);
    exp_if.push_back(32'h1111);
    next_cycle();
    quiet();
    @(negedge clk);
    check_eq("rstw_no_dm_valid2", 32'(o_dm_valid), 0);
    next_cycle();

    // Both requesters held with narrow DM reads.
    rst = 1;
    next_cycle();
    rst = 0;
    i_if_req = 1; i_if_addr = 12'h011; dm_set(0, 0, 12'h010, 32'h0);
`ifdef ARB_FAIR_EN
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check_eq("fair_if_wins", {30'h0, o_if_gnt, o_dm_gnt}, 32'b10);
        exp_if.push_back(32'h2222);
      end else begin
        check_eq("fair_dm_wins", {30'h0, o_if_gnt, o_dm_gnt}, 32'b01);
        exp_dm.push_back(32'h00001111);
      end
      next_cycle();
    end
`else
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("prio_dm_wins", {29'h0, o_if_gnt, o_dm_gnt, o_stall_fetch}, 32'b011);
      exp_dm.push_back(32'h00001111);
      next_cycle();
    end
`endif
    quiet();
    next_cycle();
    next_cycle();

    check_eq("if_queue_drained", 32'(exp_if.size()), 0);
    check_eq("dm_queue_drained", 32'(exp_dm.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
